// File: rtl/uart_pkg.sv
// Shared definitions for the uart_txrx core: parity and stop-bit encodings,
// config field widths, FSM state enums and small config helpers.
package uart_pkg;

  localparam int DLY_W  = 13;
  localparam int BITS_W = 5;
  localparam int PAR_W  = 2;
  localparam int STOP_W = 2;

  // Parity encodings; the fourth code (3) also means no parity.
  localparam logic [PAR_W-1:0] PAR_NONE = 2'd0;
  localparam logic [PAR_W-1:0] PAR_ODD  = 2'd1;
  localparam logic [PAR_W-1:0] PAR_EVEN = 2'd2;

  // Stop-bit encodings; the fourth code (3) also means two stop bits.
  localparam logic [STOP_W-1:0] STOP_ONE      = 2'd0;
  localparam logic [STOP_W-1:0] STOP_ONE_HALF = 2'd1;
  localparam logic [STOP_W-1:0] STOP_TWO      = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Out-of-range data bit counts fall back to the full data width.
  function automatic logic [BITS_W-1:0] norm_bits(input logic [BITS_W-1:0] b,
                                                  input logic [BITS_W-1:0] maxb);
    return (b == '0 || b > maxb) ? maxb : b;
  endfunction

  function automatic logic parity_en(input logic [PAR_W-1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

  // Total stop period in clocks: 1, 1.5 or 2 bit times.
  function automatic logic [DLY_W+1:0] stop_clocks(input logic [DLY_W-1:0] d,
                                                   input logic [STOP_W-1:0] s);
    case (s)
      STOP_ONE:      return {2'b00, d};
      STOP_ONE_HALF: return {2'b00, d} + {3'b000, d[DLY_W-1:1]};
      default:       return {1'b0, d, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/uart_txrx_rx.sv
// UART receiver half. Synchronises rxpin, detects a start edge, samples bits
// at their centres and pulses ready for one clock at mid first stop bit.
// Ports: clk, rst (async active-high), rxpin, cfg_* (frame config),
// data (LSB-aligned, upper bits 0), ready (1-cycle pulse), error.
module uart_txrx_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxpin,
  input  logic [DLY_W-1:0]      cfg_delay,
  input  logic [BITS_W-1:0]     cfg_bits,
  input  logic [PAR_W-1:0]      cfg_par,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  error
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state;
  logic                  s1, s2, prev;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BITS_W-1:0]     nbits;
  logic [BW-1:0]         bitn;
  logic [DLY_W-1:0]      dly, cnt;
  logic [PAR_W-1:0]      par;
  logic                  pbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      state <= RX_IDLE;
      shreg <= '0;
      nbits <= '0;
      bitn  <= '0;
      dly   <= '0;
      cnt   <= '0;
      par   <= '0;
      pbit  <= 1'b0;
      data  <= '0;
      ready <= 1'b0;
      error <= 1'b0;
    end else begin
      s1    <= rxpin;
      s2    <= s1;
      prev  <= s2;
      ready <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Edge-triggered start: after a low stop bit the line must go
          // high again before another frame can begin.
          if (prev && !s2) begin
            dly   <= cfg_delay;
            nbits <= norm_bits(cfg_bits, BITS_W'(DATA_WIDTH));
            par   <= cfg_par;
            shreg <= '0;
            pbit  <= 1'b0;
            cnt   <= {1'b0, cfg_delay[DLY_W-1:1]} - 13'd1;
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            bitn  <= '0;
            cnt   <= dly - 13'd1;
            state <= s2 ? RX_IDLE : RX_DATA;  // high at mid-start: glitch
          end else cnt <= cnt - 13'd1;
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg[bitn] <= s2;
            cnt         <= dly - 13'd1;
            if (bitn == BW'(nbits - 5'd1))
              state <= parity_en(par) ? RX_PARITY : RX_STOP;
            else
              bitn <= bitn + BW'(1);
          end else cnt <= cnt - 13'd1;
        end
        RX_PARITY: begin
          if (cnt == '0) begin
            pbit  <= s2;
            cnt   <= dly - 13'd1;
            state <= RX_STOP;
          end else cnt <= cnt - 13'd1;
        end
        RX_STOP: begin
          if (cnt == '0) begin
            data  <= shreg;
            error <= (parity_en(par) && ((^shreg ^ pbit) != (par == PAR_ODD))) || !s2;
            ready <= 1'b1;
            state <= RX_IDLE;
          end else cnt <= cnt - 13'd1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_txrx_tx.sv
// UART transmitter half. Accepts a byte in IDLE when send_tx is high, latches
// data and config for the frame, and shifts start/data/parity/stop onto txpin.
// Ports: clk, rst (async active-high), datain, send_tx, cfg_* (frame config),
// txpin (idle high), ready (high while idle).
// Optional macro UART_TX_SEND_ERROR_EN adds send_error, which inverts the
// parity bit (or the stop bits when parity is off) of the accepted frame.
module uart_txrx_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  send_tx,
`ifdef UART_TX_SEND_ERROR_EN
  input  logic                  send_error,
`endif
  input  logic [DLY_W-1:0]      cfg_delay,
  input  logic [BITS_W-1:0]     cfg_bits,
  input  logic [PAR_W-1:0]      cfg_par,
  input  logic [STOP_W-1:0]     cfg_stop,
  output logic                  txpin,
  output logic                  ready
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] mask, shreg;
  logic [BITS_W-1:0]     nbits_in, nbits;
  logic [BW-1:0]         bitn;
  logic [DLY_W-1:0]      dly;
  logic [STOP_W-1:0]     stp;
  logic [DLY_W+1:0]      cnt, dly_m1, stop_m1;
  logic                  par_en, par_val, stop_val, inv_in;

`ifdef UART_TX_SEND_ERROR_EN
  assign inv_in = send_error;
`else
  assign inv_in = 1'b0;
`endif

  assign nbits_in = norm_bits(cfg_bits, BITS_W'(DATA_WIDTH));
  assign dly_m1   = {2'b00, dly} - 15'd1;
  assign stop_m1  = stop_clocks(dly, stp) - 15'd1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) mask[i] = (i < int'(nbits_in));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      txpin    <= 1'b1;
      ready    <= 1'b1;
      shreg    <= '0;
      nbits    <= '0;
      bitn     <= '0;
      dly      <= '0;
      stp      <= '0;
      cnt      <= '0;
      par_en   <= 1'b0;
      par_val  <= 1'b0;
      stop_val <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (send_tx) begin
            shreg   <= datain & mask;
            nbits   <= nbits_in;
            dly     <= cfg_delay;
            stp     <= cfg_stop;
            par_en  <= parity_en(cfg_par);
            // Even parity is the plain XOR of the data; odd flips it.
            par_val <= (^(datain & mask)) ^ (cfg_par == PAR_ODD)
                       ^ (parity_en(cfg_par) & inv_in);
            stop_val <= ~(~parity_en(cfg_par) & inv_in);
            cnt     <= {2'b00, cfg_delay} - 15'd1;
            txpin   <= 1'b0;
            ready   <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == '0) begin
            txpin <= shreg[0];
            shreg <= shreg >> 1;
            bitn  <= '0;
            cnt   <= dly_m1;
            state <= TX_DATA;
          end else cnt <= cnt - 15'd1;
        end
        TX_DATA: begin
          if (cnt == '0) begin
            if (bitn == BW'(nbits - 5'd1)) begin
              if (par_en) begin
                txpin <= par_val;
                cnt   <= dly_m1;
                state <= TX_PARITY;
              end else begin
                txpin <= stop_val;
                cnt   <= stop_m1;
                state <= TX_STOP;
              end
            end else begin
              txpin <= shreg[0];
              shreg <= shreg >> 1;
              bitn  <= bitn + BW'(1);
              cnt   <= dly_m1;
            end
          end else cnt <= cnt - 15'd1;
        end
        TX_PARITY: begin
          if (cnt == '0) begin
            txpin <= stop_val;
            cnt   <= stop_m1;
            state <= TX_STOP;
          end else cnt <= cnt - 15'd1;
        end
        TX_STOP: begin
          if (cnt == '0) begin
            txpin <= 1'b1;
            ready <= 1'b1;
            state <= TX_IDLE;
          end else cnt <= cnt - 15'd1;
        end
        default: begin
          txpin <= 1'b1;
          ready <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART core: wires the transmitter and receiver halves to the
// shared runtime config.
// Ports: clk, rst (async active-high), uart_txpin/datain/send_tx/uart_tx_ready
// (TX side), uart_rxpin/dataout/uart_rx_ready/uart_rx_error (RX side),
// UART_CONFIG_* (delay per bit, data bits, parity, stop bits).
// Optional macro UART_TX_SEND_ERROR_EN adds input send_error_for_debug.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  uart_txpin,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  send_tx,
  output logic                  uart_tx_ready,
  input  logic                  uart_rxpin,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  uart_rx_ready,
  output logic                  uart_rx_error,
`ifdef UART_TX_SEND_ERROR_EN
  input  logic                  send_error_for_debug,
`endif
  input  logic [DLY_W-1:0]      UART_CONFIG_DELAY_FRAMES,
  input  logic [BITS_W-1:0]     UART_CONFIG_DATABITS,
  input  logic [PAR_W-1:0]      UART_CONFIG_PARITY,
  input  logic [STOP_W-1:0]     UART_CONFIG_STOPBITS
);

  uart_txrx_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .datain    (datain),
    .send_tx   (send_tx),
`ifdef UART_TX_SEND_ERROR_EN
    .send_error(send_error_for_debug),
`endif
    .cfg_delay (UART_CONFIG_DELAY_FRAMES),
    .cfg_bits  (UART_CONFIG_DATABITS),
    .cfg_par   (UART_CONFIG_PARITY),
    .cfg_stop  (UART_CONFIG_STOPBITS),
    .txpin     (uart_txpin),
    .ready     (uart_tx_ready)
  );

  uart_txrx_rx #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxpin    (uart_rxpin),
    .cfg_delay(UART_CONFIG_DELAY_FRAMES),
    .cfg_bits (UART_CONFIG_DATABITS),
    .cfg_par  (UART_CONFIG_PARITY),
    .data     (dataout),
    .ready    (uart_rx_ready),
    .error    (uart_rx_error)
  );

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: table-driven loopback frames, a
// back-to-back burst, hand-driven RX frames (bad stop bit, glitch) and a
// mid-frame reset. Received bytes are checked against a scoreboard queue.
module tb_uart_txrx;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_txpin, send_tx, uart_tx_ready, uart_rxpin;
  logic          uart_rx_ready, uart_rx_error;
  logic [DW-1:0] datain, dataout;
  logic [12:0]   cfg_dly;
  logic [4:0]    cfg_bits;
  logic [1:0]    cfg_par, cfg_stop;
  logic          loop, rx_drive;
`ifdef UART_TX_SEND_ERROR_EN
  logic          send_err;
`endif

  assign uart_rxpin = loop ? uart_txpin : rx_drive;
  always #5 clk = ~clk;

  uart_txrx #(.DATA_WIDTH(DW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .uart_txpin              (uart_txpin),
    .datain                  (datain),
    .send_tx                 (send_tx),
    .uart_tx_ready           (uart_tx_ready),
    .uart_rxpin              (uart_rxpin),
    .dataout                 (dataout),
    .uart_rx_ready           (uart_rx_ready),
    .uart_rx_error           (uart_rx_error),
`ifdef UART_TX_SEND_ERROR_EN
    .send_error_for_debug    (send_err),
`endif
    .UART_CONFIG_DELAY_FRAMES(cfg_dly),
    .UART_CONFIG_DATABITS    (cfg_bits),
    .UART_CONFIG_PARITY      (cfg_par),
    .UART_CONFIG_STOPBITS    (cfg_stop)
  );

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  typedef struct { logic [7:0] data; logic err; } exp_t;
  exp_t sb[$];

  typedef struct {
    int dly; int bits; int par; int stop;
    int data; int exp_data; int exp_pbit; int exp_low;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard consumer: every RX pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && uart_rx_ready) begin
      pulses++;
      if (sb.size() == 0) check("rx_unexpected_pulse", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", 32'(dataout), 32'(e.data));
        check("rx_error", 32'(uart_rx_error), 32'(e.err));
      end
    end
  end

  // Caller is at a negedge. Drives one request, checks acceptance, start bit,
  // parity bit (pbit >= 0) and the length of the ready-low window.
  task automatic tx_frame(input int d, input int exp_d, input logic exp_e, input bit keep,
                          input int nb, input int dly, input int pbit, input int exp_low,
                          input string tag);
    int low;
    logic start_s, par_s;
    logic [31:0] ed;
    ed = exp_d;
    datain  = d[DW-1:0];
    send_tx = 1'b1;
    @(negedge clk);
    check({tag, "_accept_ready_low"}, 32'(uart_tx_ready), 32'd0);
    sb.push_back('{ed[7:0], exp_e});
    if (!keep) send_tx = 1'b0;
    low = 0; start_s = 1'b1; par_s = 1'bx;
    while (!uart_tx_ready && low < 20000) begin
      if (low == dly / 2) start_s = uart_txpin;
      if (low == (1 + nb) * dly + dly / 2) par_s = uart_txpin;
      low++;
      @(negedge clk);
    end
    check({tag, "_start_bit"}, 32'(start_s), 32'd0);
    if (pbit >= 0) check({tag, "_parity_bit"}, 32'(par_s), 32'(pbit));
    check({tag, "_ready_low_clocks"}, 32'(low), 32'(exp_low));
  endtask

  task automatic drive_frame(input logic [9:0] fr, input int dly);
    for (int j = 0; j < 10; j++) begin
      rx_drive = fr[j];
      repeat (dly) @(negedge clk);
    end
  endtask

  initial begin
    int nb, p0;
    logic [9:0] fr;
    rst = 1'b0; send_tx = 1'b0; datain = '0; loop = 1'b1; rx_drive = 1'b1;
    cfg_dly = 13'd300; cfg_bits = 5'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
`ifdef UART_TX_SEND_ERROR_EN
    send_err = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    check("reset_txpin", 32'(uart_txpin), 32'd1);
    check("reset_tx_ready", 32'(uart_tx_ready), 32'd1);
    check("reset_dataout", 32'(dataout), 32'd0);
    check("reset_rx_ready", 32'(uart_rx_ready), 32'd0);
    check("reset_rx_error", 32'(uart_rx_error), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // dly, bits, par, stop, data, exp_data, exp_pbit, exp_low
    vt[0] = '{300,  8, 1, 2, 'h01, 'h01,  0, 3600};
    vt[1] = '{300,  7, 2, 0, 'hFF, 'h7F,  1, 3000};
    vt[2] = '{ 20,  0, 0, 0, 'hA5, 'hA5, -1,  200};
    vt[3] = '{ 20, 12, 3, 1, 'h3C, 'h3C, -1,  210};
    vt[4] = '{ 24,  5, 1, 3, 'h3F, 'h1F,  0,  216};
    vt[5] = '{ 16,  1, 2, 0, 'h01, 'h01,  1,   64};
    for (int i = 0; i < 6; i++) begin
      cfg_dly  = 13'(vt[i].dly);
      cfg_bits = 5'(vt[i].bits);
      cfg_par  = 2'(vt[i].par);
      cfg_stop = 2'(vt[i].stop);
      nb = (vt[i].bits == 0 || vt[i].bits > DW) ? DW : vt[i].bits;
      tx_frame(vt[i].data, vt[i].exp_data, 1'b0, 1'b0, nb, vt[i].dly,
               vt[i].exp_pbit, vt[i].exp_low, "vec");
      repeat (vt[i].dly) @(negedge clk);
    end

    // Back-to-back burst with send_tx held high across frames.
    cfg_dly = 13'd16; cfg_bits = 5'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
    for (int v = 2; v <= 50; v++)
      tx_frame(v, v, 1'b0, v != 50, 8, 16, -1, 160, "b2b");
    repeat (32) @(negedge clk);

    // Hand-driven RX: low stop bit, then a good frame to prove re-arm.
    loop = 1'b0; rx_drive = 1'b1; cfg_dly = 13'd32;
    repeat (10) @(negedge clk);
    p0 = pulses;
    sb.push_back('{8'h55, 1'b1});
    fr = {1'b0, 8'h55, 1'b0};
    drive_frame(fr, 32);
    repeat (64) @(negedge clk);
    check("stop_err_pulse", 32'(pulses), 32'(p0 + 1));
    rx_drive = 1'b1;
    repeat (64) @(negedge clk);
    sb.push_back('{8'hA3, 1'b0});
    fr = {1'b1, 8'hA3, 1'b0};
    drive_frame(fr, 32);
    repeat (32) @(negedge clk);
    check("rearm_pulse", 32'(pulses), 32'(p0 + 2));

    // 50-clock low glitch on an idle line at 300 clocks/bit.
    cfg_dly = 13'd300;
    p0 = pulses;
    rx_drive = 1'b0;
    repeat (50) @(negedge clk);
    rx_drive = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_pulse", 32'(pulses), 32'(p0));
    loop = 1'b1;

`ifdef UART_TX_SEND_ERROR_EN
    // Even parity of 0x10 is 1; the forced error inverts it to 0.
    cfg_dly = 13'd32; cfg_bits = 5'd8; cfg_par = 2'd2; cfg_stop = 2'd0;
    send_err = 1'b1;
    tx_frame('h10, 'h10, 1'b1, 1'b0, 8, 32, 0, 352, "dbg_err");
    send_err = 1'b0;
    repeat (32) @(negedge clk);
`endif

    // Reset in the middle of a frame.
    cfg_dly = 13'd300; cfg_bits = 5'd8; cfg_par = 2'd0; cfg_stop = 2'd0;
    datain = 8'hC3; send_tx = 1'b1;
    @(negedge clk);
    send_tx = 1'b0;
    repeat (1000) @(negedge clk);
    check("mid_frame_pin_low", 32'(uart_txpin), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_txpin", 32'(uart_txpin), 32'd1);
    check("mid_rst_tx_ready", 32'(uart_tx_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p0 = pulses;
    tx_frame('h5A, 'h5A, 1'b0, 1'b0, 8, 300, -1, 3000, "post_rst");
    repeat (300) @(negedge clk);
    check("post_rst_pulse", 32'(pulses), 32'(p0 + 1));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
